// File: rtl/otf_sd_to_binary.sv
// ----------------------------------------------------------------------------
// otf_sd_to_binary
//
// On-the-fly converter from a radix-2 signed-digit (borrow-save) stream to a
// two's complement fraction. Digits arrive MSB first, one per handshake. Two
// registers are kept: Q (the value so far) and QM (Q minus one). Every digit
// selects a shifted copy of one of them, so no carry ever has to travel
// across the word. After N_DIGITS digits, Q holds the final result and is
// presented on res until downstream takes it.
//
// Parameters
//   N_DIGITS     digits per operand; value = sum d_i * 2^-i, i = 1..N_DIGITS
//   W            result width (N_DIGITS + 1), derived from N_DIGITS
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort back to an empty accumulation
//   digit_valid  digit_p / digit_n carry a valid digit
//   digit_ready  converter can take a digit this cycle
//   digit_p      positive bit of the digit (d = digit_p - digit_n)
//   digit_n      negative bit of the digit ((1,1) also encodes 0)
//   res_valid    res holds a complete result
//   res_ready    downstream takes res
//   res          two's complement result, LSB weight 2^-N_DIGITS
//   res_zero     res is zero (meaningful only while res_valid)
// ----------------------------------------------------------------------------
module otf_sd_to_binary #(
    parameter  int N_DIGITS = 16,
    localparam int W        = N_DIGITS + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         digit_valid,
    output logic         digit_ready,
    input  logic         digit_p,
    input  logic         digit_n,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res,
    output logic         res_zero
);

    localparam int CW = $clog2(N_DIGITS + 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(N_DIGITS - 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q;
    logic [W-1:0]  qm;

    logic          accept;
    logic          dig_pos;
    logic          dig_neg;
    logic [W-1:0]  q_next;
    logic [W-1:0]  qm_next;

    // Handshake outputs depend only on the state register.
    assign digit_ready = (state == ST_ACCUM);
    assign res_valid   = (state == ST_DONE);
    assign accept      = digit_valid & digit_ready;

    // (0,0) and (1,1) both mean zero; only the unequal pairs are +1 / -1.
    assign dig_pos = digit_p & ~digit_n;
    assign dig_neg = ~digit_p & digit_n;

    // Select the next Q / QM. Dropping the top bit on each shift is exact
    // because the magnitude of the partial value always stays below one.
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        if (dig_pos) begin
            q_next  = {q[W-2:0], 1'b1};
            qm_next = {q[W-2:0], 1'b0};
        end else if (dig_neg) begin
            q_next  = {qm[W-2:0], 1'b1};
            qm_next = {qm[W-2:0], 1'b0};
        end
    end

    // Control and datapath state. clear outranks everything except reset,
    // so a digit arriving together with clear is dropped and a held result
    // is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
        end else if (clear) begin
            state <= ST_ACCUM;
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        q   <= q_next;
                        qm  <= qm_next;
                        if (cnt == LAST_CNT) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_ACCUM;
                        cnt   <= '0;
                        q     <= '0;
                        qm    <= '1;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                    cnt   <= '0;
                    q     <= '0;
                    qm    <= '1;
                end
            endcase
        end
    end

    // Q is the result register in every state; in ACCUM it is a partial
    // value that downstream ignores.
    assign res      = q;
    assign res_zero = (q == '0);

endmodule

// File: tb/tb_otf_sd_to_binary.sv
// ----------------------------------------------------------------------------
// tb_otf_sd_to_binary
//
// Bench for otf_sd_to_binary with N_DIGITS = 4. A value-level model tracks
// the accumulated number as a plain integer (value*2 + digit per accepted
// digit) together with the handshake status, and a compare process checks
// every cycle against it. Directed sequences pin the model with literal
// expected results, then a randomized phase exercises the handshakes.
// ----------------------------------------------------------------------------
module tb_otf_sd_to_binary;

    localparam int N = 4;
    localparam int W = N + 1;

    localparam logic [1:0] DP  = 2'b10;
    localparam logic [1:0] DZ  = 2'b00;
    localparam logic [1:0] DM  = 2'b01;
    localparam logic [1:0] DZZ = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         digit_valid = 1'b0;
    logic         digit_ready;
    logic         digit_p = 1'b0;
    logic         digit_n = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res;
    logic         res_zero;

    int errors = 0;
    int checks = 0;
    bit checkEnable = 1'b0;

    // Model state: whether a result is held, how many digits are in, and
    // the integer value sum d_i * 2^(j-i).
    bit modelDone  = 1'b0;
    int modelCount = 0;
    int modelValue = 0;

    otf_sd_to_binary #(.N_DIGITS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_p     (digit_p),
        .digit_n     (digit_n),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .res_zero    (res_zero)
    );

    always #5 clk = ~clk;

    // Behavioural reference, updated with the same inputs the DUT samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            modelDone  = 1'b0;
            modelCount = 0;
            modelValue = 0;
        end else if (!modelDone) begin
            if (digit_valid) begin
                modelValue = modelValue * 2 + (int'(digit_p) - int'(digit_n));
                modelCount = modelCount + 1;
                if (modelCount == N) begin
                    modelDone = 1'b1;
                end
            end
        end else if (res_ready) begin
            modelDone  = 1'b0;
            modelCount = 0;
            modelValue = 0;
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        logic [W-1:0] expRes;
        if (checkEnable) begin
            expRes = modelValue[W-1:0];
            checks = checks + 1;
            if (res_valid !== modelDone) begin
                errors = errors + 1;
                $display("[TB] FAIL model_res_valid t=%0t got=%0b exp=%0b", $time, res_valid, modelDone);
            end
            checks = checks + 1;
            if (digit_ready !== !modelDone) begin
                errors = errors + 1;
                $display("[TB] FAIL model_digit_ready t=%0t got=%0b exp=%0b", $time, digit_ready, !modelDone);
            end
            checks = checks + 1;
            if (res !== expRes) begin
                errors = errors + 1;
                $display("[TB] FAIL model_res t=%0t got=%b exp=%b", $time, res, expRes);
            end
            if (modelDone) begin
                checks = checks + 1;
                if (res_zero !== (expRes == '0)) begin
                    errors = errors + 1;
                    $display("[TB] FAIL model_res_zero t=%0t got=%0b exp=%0b", $time, res_zero, (expRes == '0));
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Waits (bounded) for a result; an expired bound counts as a failure.
    task automatic waitResult(input string name);
        int budget = 20;
        while (!res_valid && budget > 0) begin
            stepCycle();
            budget--;
        end
        checkOutput({name, "_timeout"}, int'(res_valid), 1);
    endtask

    // Sends four digits (first digit in the top pair), optionally with an
    // idle cycle after each one.
    task automatic applyStimulus(input logic [7:0] digits, input bit gapped);
        for (int i = 3; i >= 0; i--) begin
            digit_valid = 1'b1;
            digit_p     = digits[2*i+1];
            digit_n     = digits[2*i];
            stepCycle();
            if (gapped) begin
                digit_valid = 1'b0;
                stepCycle();
            end
        end
        digit_valid = 1'b0;
        digit_p     = 1'b0;
        digit_n     = 1'b0;
    endtask

    task automatic releaseResult();
        res_ready = 1'b1;
        stepCycle();
        res_ready = 1'b0;
    endtask

    task automatic runCase(input string name, input logic [7:0] digits, input bit gapped,
                           input int expRes, input int expZero);
        applyStimulus(digits, gapped);
        if (!gapped) begin
            checkOutput({name, "_latency"}, int'(res_valid), 1);
        end
        waitResult(name);
        checkOutput({name, "_res"}, int'(res), expRes);
        checkOutput({name, "_zero"}, int'(res_zero), expZero);
        releaseResult();
    endtask

    initial begin
        stepCycle();
        stepCycle();
        checkOutput("reset_digit_ready", int'(digit_ready), 1);
        checkOutput("reset_res_valid", int'(res_valid), 0);
        checkOutput("reset_res", int'(res), 0);
        checkOutput("reset_res_zero", int'(res_zero), 1);
        rst_n = 1'b1;
        checkEnable = 1'b1;
        stepCycle();

        runCase("pos_half",  {DP, DZ, DZ, DZ}, 1'b0, 5'b01000, 0);
        runCase("neg_lsb",   {DZ, DZ, DZ, DM}, 1'b0, 5'b11111, 0);
        runCase("alt",       {DP, DM, DP, DM}, 1'b0, 5'b00101, 0);
        runCase("all_neg",   {DM, DM, DM, DM}, 1'b0, 5'b10001, 0);
        runCase("zero_pair", {DZZ, DZ, DZZ, DZ}, 1'b0, 5'b00000, 1);

        // Backpressure: hold the result, poke digit_valid, then release.
        applyStimulus({DP, DM, DP, DM}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            digit_valid = 1'b1;
            digit_p     = 1'b1;
            digit_n     = 1'b0;
            stepCycle();
            checkOutput("bp_res_hold", int'(res), 5'b00101);
            checkOutput("bp_digit_ready", int'(digit_ready), 0);
        end
        digit_valid = 1'b0;
        digit_p     = 1'b0;
        releaseResult();
        checkOutput("bp_release_ready", int'(digit_ready), 1);
        checkOutput("bp_release_valid", int'(res_valid), 0);

        runCase("gapped", {DP, DZ, DZ, DZ}, 1'b1, 5'b01000, 0);

        // Reset after two digits.
        digit_valid = 1'b1; digit_p = 1'b1; digit_n = 1'b0;
        stepCycle();
        stepCycle();
        digit_valid = 1'b0;
        rst_n = 1'b0;
        stepCycle();
        checkOutput("rst_mid_ready", int'(digit_ready), 1);
        checkOutput("rst_mid_res", int'(res), 0);
        checkOutput("rst_mid_zero", int'(res_zero), 1);
        rst_n = 1'b1;
        stepCycle();
        runCase("after_rst", {DP, DP, DP, DP}, 1'b0, 5'b01111, 0);

        // Clear after two digits, with a digit offered alongside clear.
        digit_valid = 1'b1; digit_p = 1'b1; digit_n = 1'b0;
        stepCycle();
        stepCycle();
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        digit_valid = 1'b0;
        checkOutput("clr_mid_res", int'(res), 0);
        runCase("after_clr", {DP, DP, DP, DP}, 1'b0, 5'b01111, 0);

        // Clear while a result is held.
        applyStimulus({DM, DM, DM, DM}, 1'b0);
        checkOutput("clr_done_pre", int'(res_valid), 1);
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        checkOutput("clr_done_valid", int'(res_valid), 0);
        checkOutput("clr_done_ready", int'(digit_ready), 1);

        // Randomized handshakes, digits and occasional clears.
        for (int i = 0; i < 600; i++) begin
            digit_valid = 1'($urandom_range(0, 3) != 0);
            digit_p     = 1'($urandom_range(0, 1));
            digit_n     = 1'($urandom_range(0, 1));
            res_ready   = 1'($urandom_range(0, 2) == 0);
            clear       = 1'($urandom_range(0, 40) == 0);
            stepCycle();
        end
        digit_valid = 1'b0;
        res_ready   = 1'b0;
        clear       = 1'b0;
        stepCycle();
        stepCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
